// File: rtl/count_ctrl.sv
// Run-control stage for the downstream 4-bit wrap counter: prescaled enable,
// wrap counting on terminal-count rising edges, single-step and abort.
module count_ctrl #(
    parameter int DIV_W = 8,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             r,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic [DIV_W-1:0] div,
    input  logic [REP_W-1:0] reps,
    input  logic             tc,
    output logic             e,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic               e_q, e_d;
    logic               done_q, done_d;
    logic [DIV_W-1:0]   prescale_q, prescale_d;
    logic [REP_W-1:0]   wrap_q, wrap_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [REP_W-1:0]   reps_q, reps_d;
    logic               tc_q;
    logic               tc_evt;
    logic [REP_W-1:0]   wrap_inc;

    always_ff @(posedge clk) begin
        if (!r) begin
            state_q    <= IDLE;
            e_q        <= 1'b0;
            done_q     <= 1'b0;
            prescale_q <= '0;
            wrap_q     <= '0;
            div_q      <= '0;
            reps_q     <= '0;
            tc_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            e_q        <= e_d;
            done_q     <= done_d;
            prescale_q <= prescale_d;
            wrap_q     <= wrap_d;
            div_q      <= div_d;
            reps_q     <= reps_d;
            tc_q       <= tc;
        end
    end

    // tc holds until the counter's next enabled cycle, so only its rising edge counts
    assign tc_evt   = tc & ~tc_q;
    assign wrap_inc = wrap_q + REP_W'(1);

    always_comb begin
        state_d    = state_q;
        e_d        = 1'b0;
        done_d     = 1'b0;
        prescale_d = prescale_q;
        wrap_d     = wrap_q;
        div_d      = div_q;
        reps_d     = reps_q;

        case (state_q)
            IDLE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    div_d      = div;
                    reps_d     = reps;
                    prescale_d = '0;
                    wrap_d     = '0;
                    state_d    = RUN;
                end else if (step) begin
                    e_d     = 1'b1;
                    state_d = STEP;
                end
            end

            STEP: begin
                state_d = IDLE;
            end

            RUN: begin
                if (stop) begin
                    prescale_d = '0;
                    wrap_d     = '0;
                    state_d    = IDLE;
                end else if (tc_evt && (reps_q != '0) && (wrap_inc == reps_q)) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    if (prescale_q == div_q) begin
                        prescale_d = '0;
                        e_d        = 1'b1;
                    end else begin
                        prescale_d = prescale_q + DIV_W'(1);
                    end
                    if (tc_evt) begin
                        wrap_d = wrap_inc;
                    end
                end
            end

            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    div_d      = div;
                    reps_d     = reps;
                    prescale_d = '0;
                    wrap_d     = '0;
                    state_d    = RUN;
                end else begin
                    done_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign e     = e_q;
    assign busy  = (state_q == RUN) || (state_q == STEP);
    assign done  = done_q;
    assign state = state_q;

endmodule

// File: tb/tb_count_ctrl.sv
// Self-checking bench for count_ctrl: per-cycle expected {e,busy,done,state}
// is queued as stimulus is driven and compared once the clock edge has passed.
module tb_count_ctrl;

    localparam logic [4:0] IDLE_O = 5'b00000;
    localparam logic [4:0] RUN0   = 5'b01001;
    localparam logic [4:0] RUN1   = 5'b11001;
    localparam logic [4:0] STEP_O = 5'b11010;
    localparam logic [4:0] DONE_O = 5'b00111;

    logic       clk = 1'b0;
    logic       r, start, stop, step, tc, tcDrive;
    logic [7:0] div;
    logic [3:0] reps;
    logic       e, busy, done;
    logic [1:0] state;
    logic       useCounter;
    logic [3:0] cnt;

    int errors = 0;
    int checks = 0;

    logic [4:0] expQ[$];
    string      tagQ[$];

    count_ctrl #(.DIV_W(8), .REP_W(4)) dut (
        .clk(clk), .r(r), .start(start), .stop(stop), .step(step),
        .div(div), .reps(reps), .tc(tc),
        .e(e), .busy(busy), .done(done), .state(state)
    );

    always #5 clk = ~clk;

    // Downstream 4-bit wrap counter; tc stays high until its next enabled cycle
    always_ff @(posedge clk) begin
        if (!r) cnt <= 4'd0;
        else if (e) cnt <= cnt + 4'd1;
    end

    assign tc = useCounter ? (cnt == 4'hF) : tcDrive;

    task automatic checkOutput(input string tag, input logic [4:0] actual, input logic [4:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: {e,busy,done,state} got %b required %b", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic st, input logic sp,
                                 input logic stp, input logic t,
                                 input logic [4:0] exp, input string tag);
        r       = rv;
        start   = st;
        stop    = sp;
        step    = stp;
        tcDrive = t;
        expQ.push_back(exp);
        tagQ.push_back(tag);
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            checkOutput("scoreboard-empty", {e, busy, done, state}, 5'bxxxxx);
        end else begin
            checkOutput(tagQ.pop_front(), {e, busy, done, state}, expQ.pop_front());
        end
    endtask

    initial begin
        r = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; tcDrive = 1'b0;
        useCounter = 1'b0;
        div = 8'd3;
        reps = 4'd0;

        // Reset held with start asserted, then start acts on the first free edge
        applyStimulus(0, 1, 0, 0, 0, IDLE_O, "reset-1");
        applyStimulus(0, 1, 0, 0, 0, IDLE_O, "reset-2");
        applyStimulus(1, 1, 0, 0, 0, RUN0, "rst-release-start");

        // Prescale div=3: e at T+4, T+8, T+12; restart and div change ignored
        for (int k = 1; k <= 13; k++) begin
            if (k == 5) div = 8'd1;
            applyStimulus(1, (k == 5), 0, 0, 0, ((k % 4) == 0) ? RUN1 : RUN0, "prescale");
        end
        applyStimulus(1, 0, 1, 0, 0, IDLE_O, "abort-run");

        // Held tc windows: each 4-cycle high window counts once, DONE after third
        div = 8'd5;
        reps = 4'd3;
        applyStimulus(1, 1, 0, 0, 0, RUN0, "held-start");
        for (int k = 1; k <= 21; k++) begin
            int  ph;
            logic [4:0] ex;
            ph = (k - 1) % 8;
            if (k <= 17) ex = ((k % 6) == 0) ? RUN1 : RUN0;
            else ex = DONE_O;
            applyStimulus(1, 0, 0, 0, (ph >= 1 && ph <= 4), ex, "held-tc");
        end
        applyStimulus(1, 0, 1, 0, 0, IDLE_O, "done-stop");

        // Completion with the real counter: div=0, reps=2
        applyStimulus(0, 0, 0, 0, 0, IDLE_O, "reset-again");
        useCounter = 1'b1;
        div = 8'd0;
        reps = 4'd2;
        applyStimulus(1, 1, 0, 0, 0, RUN0, "cnt-start");
        for (int k = 1; k <= 35; k++) begin
            applyStimulus(1, 0, 0, 0, 0, (k <= 32) ? RUN1 : DONE_O, "cnt-run");
        end
        useCounter = 1'b0;
        applyStimulus(1, 0, 1, 0, 0, IDLE_O, "cnt-stop");

        // Step held: alternating STEP/IDLE, one e pulse per entry
        applyStimulus(1, 0, 0, 1, 0, STEP_O, "step-1");
        applyStimulus(1, 0, 0, 1, 0, IDLE_O, "step-2");
        applyStimulus(1, 0, 0, 1, 0, STEP_O, "step-3");
        applyStimulus(1, 0, 0, 0, 0, IDLE_O, "step-release");
        applyStimulus(1, 0, 1, 1, 0, IDLE_O, "stop-over-step");

        // start beats step; stop beats a completing tc edge
        div = 8'd2;
        reps = 4'd1;
        applyStimulus(1, 1, 0, 1, 0, RUN0, "start-over-step");
        applyStimulus(1, 0, 0, 0, 0, RUN0, "abort-pre");
        applyStimulus(1, 0, 1, 0, 1, IDLE_O, "stop-vs-tc");

        applyStimulus(1, 1, 0, 0, 0, RUN0, "rerun");
        applyStimulus(1, 0, 0, 0, 0, RUN0, "rerun-1");
        applyStimulus(1, 0, 0, 0, 1, DONE_O, "tc-done");
        applyStimulus(1, 0, 0, 0, 1, DONE_O, "done-hold");

        // Restart from DONE with newly latched div=1: e at T+2, T+4
        div = 8'd1;
        reps = 4'd0;
        applyStimulus(1, 1, 0, 0, 0, RUN0, "restart");
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1, 0, 0, 0, 0, ((k % 2) == 0) ? RUN1 : RUN0, "restart-div");
        end
        applyStimulus(0, 0, 0, 0, 0, IDLE_O, "reset-mid-run");
        applyStimulus(1, 0, 0, 0, 0, IDLE_O, "idle-after-reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/count_ctrl.md
Name: count_ctrl

Overview:
- Run-control stage that sits directly upstream of the 4-bit wrap counter.
- Generates the counter's enable (e) at a programmable prescaled rate.
- Watches the counter's terminal-count flag (tc) and stops after a programmed number of wraps.
- Also provides single-step and abort control, plus busy/done status for the surrounding design.

Parameters:
DIV_W, 8, width of the prescaler divisor and internal prescale counter
REP_W, 4, width of the wrap-repeat count (number of tc events per run)

Ports:
clk  input  1  system clock, all logic on rising edge
r  input  1  reset, synchronous, active-low
start  input  1  level; begin a run (latches div and reps)
stop  input  1  level; abort run or clear DONE, return to IDLE
step  input  1  level; issue exactly one e pulse from IDLE
div  input  DIV_W  prescale value; e period = div+1 cycles
reps  input  REP_W  tc events to complete a run; 0 = run until stop
tc  input  1  terminal-count flag from downstream counter (may stay high multiple cycles)
e  output  1  enable to downstream counter, registered
busy  output  1  high in RUN and STEP
done  output  1  high in DONE
state  output  2  current state encoding, for debug

Behaviour:
- Single clock domain. Reset only when r==0 at a rising clk edge; no asynchronous path.
- Values after reset:
  - state=IDLE
  - e=0, busy=0, done=0
  - prescale counter=0, wrap counter=0
  - div_q=0, reps_q=0
  - tc_q=0
- State encoding: IDLE=00, RUN=01, STEP=10, DONE=11.
- Input priority in any state: stop > start > step.
- Edge detect:
  - tc_q registers tc every cycle.
  - tc_evt = tc & ~tc_q.
  - Only rising edges count, because the downstream tc holds until its next enabled cycle.
- IDLE:
  - start: latch div_q<=div, reps_q<=reps; clear prescale and wrap counters; go to RUN.
  - step (with no start or stop): e<=1, go to STEP.
  - Otherwise e=0.
- STEP: lasts exactly one cycle with e=1. Next edge: e<=0, back to IDLE. stop during STEP returns to IDLE with e<=0 (the pulse already issued is not retracted).
- RUN, prescaler:
  - Entering RUN at cycle T (prescale=0 in T).
  - Each cycle: if prescale==div_q, then prescale<=0 and e<=1; else prescale<=prescale+1 and e<=0.
  - First e high in cycle T+div_q+1. Thereafter e is a one-cycle pulse every div_q+1 cycles.
  - div_q=0 gives e continuously high from T+1.
- RUN, wrap counting:
  - On tc_evt: if reps_q!=0 and wrap_cnt+1==reps_q, go to DONE, with e<=0 and done<=1 on that edge.
  - Otherwise wrap_cnt<=wrap_cnt+1, wrapping modulo 2^REP_W.
  - reps_q==0: never completes; only stop exits.
- RUN, abort: stop goes to IDLE next edge, e<=0, counters cleared. stop wins over a simultaneous completing tc_evt, so the result is IDLE with done=0.
- RUN, restart: start while already in RUN is ignored. Changes to div/reps during RUN are ignored until the next start.
- DONE:
  - done=1, busy=0, e=0.
  - stop: go to IDLE, done<=0.
  - start: re-latch div/reps, clear counters, go to RUN, done<=0.
  - tc ignored.
- Arithmetic: prescale compare is unsigned DIV_W-bit; wrap compare is unsigned REP_W-bit. No saturation needed.
- Reset mid-operation: any state returns to reset values on the reset edge; e drops the same edge.

Test Plan:
- Reset: hold r=0 two cycles with start=1 -> e=0, busy=0, done=0, state=00. Release r -> IDLE; start=1 then takes effect on the next edge.
- Prescale: div=3, reps=0, start pulse one cycle, tc tied 0 -> e high in cycles T+4, T+8, T+12 only, where T is the first RUN cycle; busy=1 throughout; state=01.
- Completion with real counter attached: div=0, reps=2, 4-bit counter downstream -> done rises on the second tc rising edge; e=0 from that edge on; state=11; busy=0.
- Held tc: div=5, reps=3, tc driven high for 4 consecutive cycles then low, repeated -> each high window counts once; DONE after the third window, not earlier.
- Step and priority:
  - From IDLE, step=1 for 3 cycles -> e high for exactly one cycle per STEP entry (alternating STEP/IDLE while step is held).
  - start=1 and step=1 together -> RUN.
- Abort and simultaneity: in RUN with reps=1, assert stop in the same cycle as a tc rising edge -> IDLE, done=0, e=0. Then start=1 from DONE -> run restarts with newly latched div.
